sprite_engine: RTL

- Parametrised successor to the single-sprite mover/painter.
- Owns one sprite's screen position, streams its pixels to the VGA adapter from external sprite ROM, erases with a background colour, and moves on a divided tick.
- Adds configurable sprite size, step and bounds, diagonal motion, pipelined ROM read and bounding-box bullet collision.
- Sits between the keyboard decode, the sprite ROM and the shared VGA adapter write port.

---
 rtl/sprite_pkg.sv | 18 +
 rtl/sprite_scan.sv | 93 +++++++++
 rtl/sprite_engine.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared state encoding and screen geometry for the sprite engine.
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        HOLD,
        ERASE,
        MOVE,
        DEAD
    } state_t;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int VGA_X_W  = 9;
    localparam int VGA_Y_W  = 8;

endpackage

// File: rtl/sprite_scan.sv
// Sprite scan: row-major ROM address counter plus one registered pixel stage.
// SPRITE_ENGINE_TRANSPARENT_EN suppresses draw strobes for TRANSPARENT_COLOR.
module sprite_scan
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int COLOR_W  = 3,
    parameter logic [COLOR_W-1:0] BG_COLOR = '1
`ifdef SPRITE_ENGINE_TRANSPARENT_EN
    ,
    parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = '0
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          go,
    input  logic                          erase,
    input  logic [VGA_X_W-1:0]            org_x,
    input  logic [VGA_Y_W-1:0]            org_y,
    input  logic [COLOR_W-1:0]            mem_color,
    output logic [$clog2(SPRITE_W)-1:0]   mem_xc,
    output logic [$clog2(SPRITE_H)-1:0]   mem_yc,
    output logic [VGA_X_W-1:0]            vga_x,
    output logic [VGA_Y_W-1:0]            vga_y,
    output logic [COLOR_W-1:0]            vga_color,
    output logic                          vga_plot,
    output logic                          done,
    output logic                          busy
);

    localparam int XC_W = $clog2(SPRITE_W);
    localparam int YC_W = $clog2(SPRITE_H);

    logic active;
    logic out_valid;
    logic erase_mode;
    logic draw_vis;
    logic last_col;
    logic last_row;

`ifdef SPRITE_ENGINE_TRANSPARENT_EN
    assign draw_vis = (mem_color != TRANSPARENT_COLOR);
`else
    assign draw_vis = 1'b1;
`endif

    assign last_col = (mem_xc == XC_W'(SPRITE_W - 1));
    assign last_row = (mem_yc == YC_W'(SPRITE_H - 1));

    // out_valid trails active by one cycle, so busy also covers the flush pixel.
    assign busy = active | out_valid;
    assign done = out_valid & ~active;

    always_ff @(posedge clk) begin
        if (rst) begin
            active     <= 1'b0;
            out_valid  <= 1'b0;
            erase_mode <= 1'b0;
            mem_xc     <= '0;
            mem_yc     <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_color  <= '0;
            vga_plot   <= 1'b0;
        end else begin
            out_valid <= active;
            vga_plot  <= active && (erase_mode || draw_vis);
            if (active) begin
                vga_x     <= org_x + VGA_X_W'(mem_xc);
                vga_y     <= org_y + VGA_Y_W'(mem_yc);
                vga_color <= erase_mode ? BG_COLOR : mem_color;
                if (last_col) begin
                    mem_xc <= '0;
                    if (last_row) begin
                        mem_yc <= '0;
                        active <= 1'b0;
                    end else begin
                        mem_yc <= mem_yc + 1'b1;
                    end
                end else begin
                    mem_xc <= mem_xc + 1'b1;
                end
            end else if (go) begin
                active     <= 1'b1;
                erase_mode <= erase;
                mem_xc     <= '0;
                mem_yc     <= '0;
            end
        end
    end

endmodule

// File: rtl/sprite_engine.sv
// Sprite engine: position FSM, move-tick divider, clamped motion and bullet collision.
// SPRITE_ENGINE_TRANSPARENT_EN adds TRANSPARENT_COLOR (draw-only pixel skipping).
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int COLOR_W  = 3,
    parameter int X_INIT   = 160,
    parameter int Y_INIT   = 120,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = SCREEN_W - 1,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = SCREEN_H - 1,
    parameter int STEP     = 1,
    parameter int MOVE_DIV = 500000,
    parameter logic [COLOR_W-1:0] BG_COLOR = '1
`ifdef SPRITE_ENGINE_TRANSPARENT_EN
    ,
    parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = '0
`endif
) (
    input  logic                          CLOCK_50,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          up,
    input  logic                          down,
    input  logic                          left,
    input  logic                          right,
    input  logic [COLOR_W-1:0]            mem_color,
    output logic [$clog2(SPRITE_W)-1:0]   mem_xc,
    output logic [$clog2(SPRITE_H)-1:0]   mem_yc,
    output logic [VGA_X_W-1:0]            vga_x,
    output logic [VGA_Y_W-1:0]            vga_y,
    output logic [COLOR_W-1:0]            vga_color,
    output logic                          vga_plot,
    output logic [VGA_X_W-1:0]            obj_x,
    output logic [VGA_Y_W-1:0]            obj_y,
    input  logic [VGA_X_W-1:0]            bullet_x,
    input  logic [VGA_Y_W-1:0]            bullet_y,
    input  logic                          bullet_valid,
    output logic                          hit,
    output logic                          busy
);

    localparam int DIV_W = $clog2(MOVE_DIV);
    localparam logic signed [11:0] STEP_S = 12'(STEP);
    localparam logic signed [11:0] X_LO   = 12'(X_MIN);
    localparam logic signed [11:0] X_HI   = 12'(X_MAX - SPRITE_W + 1);
    localparam logic signed [11:0] Y_LO   = 12'(Y_MIN);
    localparam logic signed [11:0] Y_HI   = 12'(Y_MAX - SPRITE_H + 1);

    state_t state, next_state;

    logic [DIV_W-1:0]   tick_cnt;
    logic               tick;
    logic               running;
    logic               go_q;
    logic               erase_q;
    logic               scan_done;
    logic               coll;
    logic               move_ok;
    logic signed [11:0] dx, dy, cx, cy;
    logic [VGA_X_W-1:0] cand_x, next_x;
    logic [VGA_Y_W-1:0] cand_y, next_y;
    logic [VGA_X_W:0]   box_x_hi;
    logic [VGA_Y_W:0]   box_y_hi;

    assign running = (state != IDLE) && (state != DEAD);
    assign tick    = running && (tick_cnt == DIV_W'(MOVE_DIV - 1));

    // Candidate is computed in signed 12-bit so a step past either edge clamps instead of wrapping.
    always_comb begin
        dx = '0;
        dy = '0;
        if (right) dx = dx + STEP_S;
        if (left)  dx = dx - STEP_S;
        if (down)  dy = dy + STEP_S;
        if (up)    dy = dy - STEP_S;
        cx = $signed({3'b000, obj_x}) + dx;
        cy = $signed({4'b0000, obj_y}) + dy;
        if (cx < X_LO)      cand_x = X_LO[VGA_X_W-1:0];
        else if (cx > X_HI) cand_x = X_HI[VGA_X_W-1:0];
        else                cand_x = cx[VGA_X_W-1:0];
        if (cy < Y_LO)      cand_y = Y_LO[VGA_Y_W-1:0];
        else if (cy > Y_HI) cand_y = Y_HI[VGA_Y_W-1:0];
        else                cand_y = cy[VGA_Y_W-1:0];
    end

    assign move_ok  = (cand_x != obj_x) || (cand_y != obj_y);
    assign box_x_hi = {1'b0, obj_x} + (VGA_X_W + 1)'(SPRITE_W - 1);
    assign box_y_hi = {1'b0, obj_y} + (VGA_Y_W + 1)'(SPRITE_H - 1);
    assign coll     = bullet_valid
                   && (bullet_x >= obj_x) && ({1'b0, bullet_x} <= box_x_hi)
                   && (bullet_y >= obj_y) && ({1'b0, bullet_y} <= box_y_hi);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = DRAW;
            DRAW:    if (scan_done) next_state = HOLD;
            HOLD:    if (hit || (tick && move_ok)) next_state = ERASE;
            ERASE:   if (scan_done) next_state = hit ? DEAD : MOVE;
            MOVE:    next_state = DRAW;
            DEAD:    next_state = DEAD;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state    <= IDLE;
            obj_x    <= VGA_X_W'(X_INIT);
            obj_y    <= VGA_Y_W'(Y_INIT);
            next_x   <= VGA_X_W'(X_INIT);
            next_y   <= VGA_Y_W'(Y_INIT);
            hit      <= 1'b0;
            tick_cnt <= '0;
            go_q     <= 1'b0;
            erase_q  <= 1'b0;
        end else begin
            state   <= next_state;
            go_q    <= (next_state != state) && ((next_state == DRAW) || (next_state == ERASE));
            erase_q <= (next_state == ERASE);
            if (running) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (running && coll) hit <= 1'b1;
            if ((state == HOLD) && !hit && tick && move_ok) begin
                next_x <= cand_x;
                next_y <= cand_y;
            end
            if (state == MOVE) begin
                obj_x <= next_x;
                obj_y <= next_y;
            end
        end
    end

    sprite_scan #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .COLOR_W  (COLOR_W),
        .BG_COLOR (BG_COLOR)
`ifdef SPRITE_ENGINE_TRANSPARENT_EN
        ,
        .TRANSPARENT_COLOR (TRANSPARENT_COLOR)
`endif
    ) u_scan (
        .clk       (CLOCK_50),
        .rst       (rst),
        .go        (go_q),
        .erase     (erase_q),
        .org_x     (obj_x),
        .org_y     (obj_y),
        .mem_color (mem_color),
        .mem_xc    (mem_xc),
        .mem_yc    (mem_yc),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_color (vga_color),
        .vga_plot  (vga_plot),
        .done      (scan_done),
        .busy      (busy)
    );

endmodule
